// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared constants for the USB line encoder (and the matching decoder).
//   LINE_J / LINE_K / LINE_SE0 : 2-bit {d_plus, d_minus} line states
//   STUFF_LIMIT                : run of 1s that forces a stuffed 0
//   encoder_state_t            : transmit encoder FSM states
//   nrziLine()                 : maps an NRZI level (1 = J) to a line state
// ---------------------------------------------------------------------------
package usb_pkg;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int unsigned STUFF_LIMIT = 6;

  typedef enum logic [2:0] {
    ST_NORMAL = 3'd0,
    ST_STUFF  = 3'd1,
    ST_EOP1   = 3'd2,
    ST_EOP2   = 3'd3,
    ST_EOP_J  = 3'd4
  } encoder_state_t;

  // The NRZI level is kept as a single bit where 1 means the line idles at J.
  function automatic logic [1:0] nrziLine(input logic level);
    return level ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_edge_detect.sv
// ---------------------------------------------------------------------------
// usb_edge_detect
// Rising-edge detector for a level strobe. The previous sample is registered,
// so a strobe held high for many cycles yields a single one-cycle pulse on the
// first cycle it is seen high after being seen low.
//   clk     : system clock
//   n_rst   : asynchronous active-low reset (previous sample clears to 0)
//   i_level : strobe being watched
//   o_rise  : high in the cycle where i_level is high and was low last cycle
// ---------------------------------------------------------------------------
module usb_edge_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's strobe level so only the first high cycle counts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/usb_encoder.sv
// ---------------------------------------------------------------------------
// usb_encoder
// Transmit-side USB line encoder: bit stuffing, NRZI and EOP generation.
//   clk          : system clock
//   n_rst        : asynchronous active-low reset
//   tx_out_bit   : serial data bit, consumed on each shift event
//   tx_shift     : bit-time strobe; its rising edge is the shift event
//   create_eop   : request to end the packet (level, armed on any high cycle)
//   tx_hold      : high while a stuff bit is pending; upstream must hold data
//   d_plus_out   : D+ line (registered)
//   d_minus_out  : D- line (registered)
// ---------------------------------------------------------------------------
module usb_encoder
  import usb_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic tx_out_bit,
  input  logic tx_shift,
  input  logic create_eop,
  output logic tx_hold,
  output logic d_plus_out,
  output logic d_minus_out
);

  logic           w_shiftEvent;
  logic [2:0]     w_onesNext;
  logic           w_armAllowed;

  encoder_state_t r_state;
  logic [1:0]     r_line;
  logic           r_level;
  logic [2:0]     r_onesCount;
  logic           r_txHold;
  logic           r_eopArmed;

  usb_edge_detect u_shiftEdge (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_level (tx_shift),
    .o_rise  (w_shiftEvent)
  );

  assign w_onesNext   = r_onesCount + 3'd1;
  // Once the EOP sequence is under way a new request has nothing to end.
  assign w_armAllowed = (r_state == ST_NORMAL) || (r_state == ST_STUFF);

  // Main encoder: everything advances only on a shift event, except the EOP
  // request flag which is sampled every cycle. An armed request seen in NORMAL
  // starts the EOP on that very event (it drives the first SE0 itself, no data
  // bit is consumed), so the FSM jumps straight past EOP1 to EOP2. EOP1 is
  // only occupied when the request lands while a stuff bit is pending, so the
  // stuff bit goes out first.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_NORMAL;
      r_line      <= LINE_J;
      r_level     <= 1'b1;
      r_onesCount <= '0;
      r_txHold    <= 1'b0;
      r_eopArmed  <= 1'b0;
    end else begin
      if (create_eop && w_armAllowed) begin
        r_eopArmed <= 1'b1;
      end

      if (w_shiftEvent) begin
        case (r_state)
          ST_NORMAL: begin
            if (r_eopArmed) begin
              r_line      <= LINE_SE0;
              r_onesCount <= '0;
              r_eopArmed  <= 1'b0;
              r_state     <= ST_EOP2;
            end else if (tx_out_bit) begin
              r_line      <= nrziLine(r_level);
              r_onesCount <= w_onesNext;
              if (w_onesNext == 3'(STUFF_LIMIT)) begin
                r_state  <= ST_STUFF;
                r_txHold <= 1'b1;
              end
            end else begin
              r_level     <= ~r_level;
              r_line      <= nrziLine(~r_level);
              r_onesCount <= '0;
            end
          end

          ST_STUFF: begin
            r_level     <= ~r_level;
            r_line      <= nrziLine(~r_level);
            r_onesCount <= '0;
            r_txHold    <= 1'b0;
            if (r_eopArmed) begin
              r_eopArmed <= 1'b0;
              r_state    <= ST_EOP1;
            end else begin
              r_state <= ST_NORMAL;
            end
          end

          ST_EOP1: begin
            r_line  <= LINE_SE0;
            r_state <= ST_EOP2;
          end

          ST_EOP2: begin
            r_line  <= LINE_SE0;
            r_state <= ST_EOP_J;
          end

          ST_EOP_J: begin
            r_line      <= LINE_J;
            r_level     <= 1'b1;
            r_onesCount <= '0;
            r_state     <= ST_NORMAL;
          end

          default: begin
            r_state <= ST_NORMAL;
          end
        endcase
      end
    end
  end

  assign tx_hold     = r_txHold;
  assign d_plus_out  = r_line[1];
  assign d_minus_out = r_line[0];

endmodule

// File: tb/tb_usb_encoder.sv
// ---------------------------------------------------------------------------
// tb_usb_encoder
// Scoreboard bench for usb_encoder. The reference model turns the request
// stream into a queue of line symbols (data bits, stuffed zeros, SE0/J of the
// end-of-packet) and NRZI-encodes one symbol per shift event.
// ---------------------------------------------------------------------------
module tb_usb_encoder;

  localparam logic [2:0] EXP_IDLE = 3'b100;

  localparam int SYM_D0   = 0;
  localparam int SYM_D1   = 1;
  localparam int SYM_STF  = 2;
  localparam int SYM_SE0  = 3;
  localparam int SYM_EOPJ = 4;

  logic clk        = 1'b0;
  logic n_rst      = 1'b0;
  logic tx_out_bit = 1'b0;
  logic tx_shift   = 1'b0;
  logic create_eop = 1'b0;
  logic tx_hold;
  logic d_plus_out;
  logic d_minus_out;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] expQ[$];
  int         symQ[$];
  int         onesRun;
  logic       level;
  logic       armed;
  logic [2:0] lastExp;

  usb_encoder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .tx_out_bit  (tx_out_bit),
    .tx_shift    (tx_shift),
    .create_eop  (create_eop),
    .tx_hold     (tx_hold),
    .d_plus_out  (d_plus_out),
    .d_minus_out (d_minus_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got {dp,dm,hold}=%b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic void resetModel();
    symQ.delete();
    expQ.delete();
    onesRun = 0;
    level   = 1'b1;
    armed   = 1'b0;
    lastExp = EXP_IDLE;
  endfunction

  function automatic void pushEop();
    symQ.push_back(SYM_SE0);
    symQ.push_back(SYM_SE0);
    symQ.push_back(SYM_EOPJ);
    armed   = 1'b0;
    onesRun = 0;
  endfunction

  // One shift event: refill the symbol stream if empty, send its head.
  function automatic void modelEvent(input logic b);
    int         sym;
    logic [1:0] line;
    logic       hold;
    if (symQ.size() == 0) begin
      if (armed) begin
        pushEop();
      end else begin
        symQ.push_back(b ? SYM_D1 : SYM_D0);
        if (b) begin
          onesRun++;
          if (onesRun == 6) begin
            symQ.push_back(SYM_STF);
            onesRun = 0;
          end
        end else begin
          onesRun = 0;
        end
      end
    end
    sym = symQ.pop_front();
    case (sym)
      SYM_D0, SYM_STF: begin
        level = ~level;
        line  = level ? 2'b10 : 2'b01;
      end
      SYM_D1:  line = level ? 2'b10 : 2'b01;
      SYM_SE0: line = 2'b00;
      default: begin
        level = 1'b1;
        line  = 2'b10;
      end
    endcase
    if (sym == SYM_STF && armed) begin
      pushEop();
    end
    hold = 1'b0;
    if (symQ.size() > 0) begin
      hold = (symQ[0] == SYM_STF);
    end
    lastExp = {line, hold};
    expQ.push_back(lastExp);
  endfunction

  function automatic void modelArm();
    logic inEop;
    inEop = 1'b0;
    foreach (symQ[i]) begin
      if (symQ[i] == SYM_SE0 || symQ[i] == SYM_EOPJ) inEop = 1'b1;
    end
    if (!inEop) armed = 1'b1;
  endfunction

  task automatic applyStimulus(input logic b, input int hi, input int lo);
    @(negedge clk);
    checkOutput("hold between events", {d_plus_out, d_minus_out, tx_hold}, lastExp);
    modelEvent(b);
    tx_out_bit = b;
    tx_shift   = 1'b1;
    repeat (hi) @(negedge clk);
    tx_shift = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulseEop(input int n);
    @(negedge clk);
    create_eop = 1'b1;
    modelArm();
    repeat (n) @(negedge clk);
    create_eop = 1'b0;
  endtask

  task automatic applyReset(input int cyc);
    @(negedge clk);
    n_rst      = 1'b0;
    tx_shift   = 1'b0;
    create_eop = 1'b0;
    #1;
    resetModel();
    checkOutput("async reset", {d_plus_out, d_minus_out, tx_hold}, EXP_IDLE);
    repeat (cyc) @(negedge clk);
    checkOutput("held in reset", {d_plus_out, d_minus_out, tx_hold}, EXP_IDLE);
    n_rst = 1'b1;
  endtask

  // Monitor: tracks shift events from the strobe itself and compares the
  // registered outputs just after each event edge against the scoreboard.
  initial begin
    logic tbPrev;
    logic evt;
    tbPrev = 1'b0;
    forever begin
      @(posedge clk);
      evt    = n_rst && tx_shift && !tbPrev;
      tbPrev = n_rst && tx_shift;
      if (evt) begin
        #1;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected event at %0t: got {dp,dm,hold}=%b expected none queued",
                   $time, {d_plus_out, d_minus_out, tx_hold});
        end else begin
          checkOutput("line after event", {d_plus_out, d_minus_out, tx_hold}, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    logic [5:0] nrziPat;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("reset state", {d_plus_out, d_minus_out, tx_hold}, EXP_IDLE);
    n_rst = 1'b1;

    // Ten 1s: stuff after the sixth, then 0,0,1,0,1,1.
    repeat (10) applyStimulus(1'b1, 1, 0);
    nrziPat = 6'b001011;
    for (int i = 5; i >= 0; i--) applyStimulus(nrziPat[i], 1, 0);

    // EOP with two-cycle strobes, then a 1 that keeps J.
    pulseEop(2);
    repeat (3) applyStimulus(1'($urandom_range(0, 1)), 2, 0);
    applyStimulus(1'b1, 1, 0);

    // Long strobe: one toggle only.
    applyStimulus(1'b0, 5, 1);
    applyStimulus(1'b1, 1, 0);

    // Reset mid-stuff, then six fresh 1s and the stuff bit.
    repeat (6) applyStimulus(1'b1, 1, 0);
    applyReset(2);
    repeat (7) applyStimulus(1'b1, 1, 0);

    // EOP requested while a stuff bit is pending; a request during EOP is ignored.
    repeat (6) applyStimulus(1'b1, 1, 1);
    pulseEop(1);
    applyStimulus(1'b0, 1, 0);
    applyStimulus(1'b0, 1, 0);
    pulseEop(1);
    repeat (4) applyStimulus(1'b0, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) pulseEop(int'($urandom_range(1, 3)));
      else if ($urandom_range(0, 99) == 0) applyReset(1);
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
